// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: DEPTH-entry character FIFO feeding a frame serialiser
// with programmable bit period, optional even/odd parity and 1 or 2 stop bits.
module uart_tx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int DIV_W     = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [DATA_BITS-1:0]   DATA_IN,
    input  logic                   WE,
    input  logic [DIV_W-1:0]       DIV,
    input  logic [1:0]             PARITY,
    input  logic                   STOP2,
    output logic                   DATA_OUT,
    output logic                   BUSY,
    output logic                   FULL,
    output logic                   EMPTY,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic                   OVF,
    output logic                   DONE
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    function automatic logic [DIV_W-1:0] bit_period(input logic [DIV_W-1:0] div);
        return (div < DIV_W'(2)) ? DIV_W'(2) : div;
    endfunction

    function automatic logic frame_parity(input logic [DATA_BITS-1:0] d, input logic [1:0] mode);
        return (^d) ^ (mode == 2'b10);
    endfunction

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 push, pop;
    logic                 ovf_q;

    state_t               state, state_n;
    logic [DIV_W-1:0]     div_cnt;
    logic [3:0]           bit_cnt;
    logic                 line_q, line_n;
    logic                 done_q, frame_end;
    logic                 tick, last_data;

    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 use_par;
    logic                 stop2_l;
    logic [DIV_W-1:0]     period;

    assign FULL     = (count == (AW+1)'(DEPTH));
    assign EMPTY    = (count == '0);
    assign COUNT    = count;
    assign OVF      = ovf_q;
    assign DONE     = done_q;
    assign DATA_OUT = line_q;
    assign BUSY     = (state != IDLE) || !EMPTY;

    assign push      = WE && !FULL;
    assign tick      = (div_cnt == period - 1'b1);
    assign last_data = (bit_cnt == 4'(DATA_BITS-1));

    // FIFO: a write into a full FIFO is dropped even if a pop happens alongside it
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            ovf_q <= WE && FULL;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= DATA_IN;
    end

    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        line_n    = 1'b1;
        frame_end = 1'b0;
        unique case (state)
            IDLE: begin
                if (!EMPTY) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                line_n = 1'b0;
                if (tick) state_n = DATA;
            end
            DATA: begin
                line_n = shreg[0];
                if (tick && last_data) state_n = use_par ? PAR : STOP;
            end
            PAR: begin
                line_n = par_bit;
                if (tick) state_n = STOP;
            end
            STOP: begin
                // bit_cnt[0] marks the second stop period when two are configured
                if (tick && (!stop2_l || bit_cnt[0])) begin
                    frame_end = 1'b1;
                    if (!EMPTY) begin
                        pop     = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The line and DONE are registered, so both trail the state by one clock
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            line_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state  <= state_n;
            line_q <= line_n;
            done_q <= frame_end;
            if (state == IDLE || tick) div_cnt <= '0;
            else                       div_cnt <= div_cnt + 1'b1;
            if (state == IDLE)         bit_cnt <= '0;
            else if (tick)             bit_cnt <= (state_n != state) ? 4'd0 : bit_cnt + 1'b1;
        end
    end

    // Frame-local copies of the character and configuration, captured at pop
    always_ff @(posedge CLK) begin
        if (pop) begin
            shreg   <= mem[rd_ptr];
            par_bit <= frame_parity(mem[rd_ptr], PARITY);
            use_par <= (PARITY == 2'b01) || (PARITY == 2'b10);
            stop2_l <= STOP2;
            period  <= bit_period(DIV);
        end else if (state == DATA && tick) begin
            shreg <= shreg >> 1;
        end
    end

endmodule
